// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divider's shift register and
// its control.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 16;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step_counter.sv
// Saturating step counter with clear and enable. tc flags the enabled
// increment that lands on the terminal value STEPS.
module div_step_counter
    import div_pkg::*;
#(
    parameter int STEPS = DIV_STEPS,
    parameter int CW    = $clog2(STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] TERM = CW'(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/div_shift_reg.sv
// Quotient/remainder shift register: STEPS shifts per operation in a latched
// direction, inserting ins_bit at the vacated end, with done/busy handshake.
module div_shift_reg
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    parameter  int STEPS = DIV_STEPS,
    localparam int CW    = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             shift_en,
    input  logic             ins_bit,
    output logic [WIDTH-1:0] q,
    output logic             out_bit,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             out_bit_q, out_bit_d;
    logic             dir_q, dir_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    div_step_counter #(
        .STEPS (STEPS),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (count),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        out_bit_d = out_bit_q;
        dir_d     = dir_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        // load takes priority over any shift, in every state
        if (load) begin
            q_d       = load_val;
            dir_d     = dir;
            out_bit_d = 1'b0;
            cnt_clr   = 1'b1;
            state_d   = RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (shift_en) begin
                        cnt_en = 1'b1;
                        if (dir_q == DIR_RIGHT) begin
                            q_d       = {ins_bit, q_q[WIDTH-1:1]};
                            out_bit_d = q_q[0];
                        end else begin
                            q_d       = {q_q[WIDTH-2:0], ins_bit};
                            out_bit_d = q_q[WIDTH-1];
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (cnt_tc) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            q_q       <= '0;
            out_bit_q <= 1'b0;
            dir_q     <= DIR_LEFT;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            out_bit_q <= out_bit_d;
            dir_q     <= dir_d;
        end
    end

    assign q       = q_q;
    assign out_bit = out_bit_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_div_shift_reg.sv
// Directed bench: a 32/31 instance for the legacy shift and reset cases and a
// 16/4 instance for right shifts, stalls, abort and back-to-back operations.
module tb_div_shift_reg;

    logic clk;
    logic rst_n;

    logic        load_a, dir_a, shift_en_a, ins_bit_a;
    logic [31:0] load_val_a, q_a;
    logic        out_bit_a, busy_a, done_a;
    logic [4:0]  count_a;

    logic        load_b, dir_b, shift_en_b, ins_bit_b;
    logic [15:0] load_val_b, q_b;
    logic        out_bit_b, busy_b, done_b;
    logic [2:0]  count_b;

    int checks_n;
    int errors_n;
    int pulses_b;
    int base;

    div_shift_reg #(.WIDTH(32), .STEPS(31)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_a),
        .load_val (load_val_a),
        .dir      (dir_a),
        .shift_en (shift_en_a),
        .ins_bit  (ins_bit_a),
        .q        (q_a),
        .out_bit  (out_bit_a),
        .count    (count_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    div_shift_reg #(.WIDTH(16), .STEPS(4)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_b),
        .load_val (load_val_b),
        .dir      (dir_b),
        .shift_en (shift_en_b),
        .ins_bit  (ins_bit_b),
        .q        (q_b),
        .out_bit  (out_bit_b),
        .count    (count_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_b) pulses_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_b_op(input logic [15:0] v, input logic d,
                             input logic ib, input logic se);
        load_b = 1'b1; load_val_b = v; dir_b = d;
        ins_bit_b = ib; shift_en_b = se;
        step();
        load_b = 1'b0;
    endtask

    logic [15:0] st_q   [7];
    logic [2:0]  st_cnt [7];
    logic        st_en  [7];
    logic        st_dn  [7];
    logic [15:0] bb_q   [4];

    initial begin
        checks_n = 0; errors_n = 0; pulses_b = 0;
        rst_n = 1'b0;
        load_a = 0; dir_a = 0; shift_en_a = 0; ins_bit_a = 0; load_val_a = '0;
        load_b = 0; dir_b = 0; shift_en_b = 0; ins_bit_b = 0; load_val_b = '0;
        st_en  = '{1, 0, 0, 1, 0, 1, 1};
        st_q   = '{16'h0003, 16'h0003, 16'h0003, 16'h0007,
                   16'h0007, 16'h000F, 16'h001F};
        st_cnt = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        st_dn  = '{0, 0, 0, 0, 0, 0, 1};
        bb_q   = '{16'h2222, 16'h4444, 16'h8888, 16'h1110};
        step(); step();
        chk("rst_q", q_a, 32'h0);
        chk("rst_cnt", 32'(count_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        rst_n = 1'b1;
        step();

        // IDLE ignores shift_en
        shift_en_a = 1'b1; ins_bit_a = 1'b1;
        step(); step();
        chk("idle_q", q_a, 32'h0);
        chk("idle_busy", 32'(busy_a), 32'h0);

        // legacy left shift, inserting ones
        load_a = 1'b1; load_val_a = 32'h1; dir_a = 1'b0; shift_en_a = 1'b0;
        step();
        load_a = 1'b0;
        chk("lg_load_q", q_a, 32'h1);
        chk("lg_load_busy", 32'(busy_a), 32'h1);
        shift_en_a = 1'b1;
        step();
        chk("lg_s1_q", q_a, 32'h3);
        chk("lg_s1_cnt", 32'(count_a), 32'd1);
        chk("lg_s1_done", 32'(done_a), 32'h0);
        for (int k = 2; k <= 30; k++) begin
            step();
            chk("lg_mid_done", 32'(done_a), 32'h0);
        end
        chk("lg_s30_q", q_a, 32'h7FFF_FFFF);
        step();
        chk("lg_fin_q", q_a, 32'hFFFF_FFFF);
        chk("lg_fin_ob", 32'(out_bit_a), 32'h0);
        chk("lg_fin_cnt", 32'(count_a), 32'd31);
        chk("lg_fin_done", 32'(done_a), 32'h1);
        chk("lg_fin_busy", 32'(busy_a), 32'h0);
        step();
        chk("lg_post_done", 32'(done_a), 32'h0);
        chk("lg_post_q", q_a, 32'hFFFF_FFFF);
        chk("lg_post_cnt", 32'(count_a), 32'd31);

        // async reset mid-operation
        load_a = 1'b1; load_val_a = 32'hDEAD_BEEF;
        step();
        load_a = 1'b0;
        repeat (5) step();
        chk("ar_cnt5", 32'(count_a), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_q", q_a, 32'h0);
        chk("ar_cnt", 32'(count_a), 32'h0);
        chk("ar_busy", 32'(busy_a), 32'h0);
        chk("ar_done", 32'(done_a), 32'h0);
        chk("ar_ob", 32'(out_bit_a), 32'h0);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("ar_idle_q", q_a, 32'h0);
        chk("ar_idle_done", 32'(done_a), 32'h0);
        shift_en_a = 1'b0;
        pulses_b = 0;

        // right shift inserting zeros
        load_b_op(16'h8001, 1'b1, 1'b0, 1'b0);
        shift_en_b = 1'b1;
        step();
        chk("rs_s1_q", 32'(q_b), 32'h4000);
        chk("rs_s1_ob", 32'(out_bit_b), 32'h1);
        step();
        chk("rs_s2_ob", 32'(out_bit_b), 32'h0);
        step(); step();
        chk("rs_s4_q", 32'(q_b), 32'h0800);
        chk("rs_s4_done", 32'(done_b), 32'h1);
        shift_en_b = 1'b0;
        step(); step();
        chk("rs_pulses", 32'(pulses_b), 32'd1);
        chk("rs_idle_q", 32'(q_b), 32'h0800);

        // stalls
        load_b_op(16'h0001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            shift_en_b = st_en[i];
            step();
            chk("st_q", 32'(q_b), 32'(st_q[i]));
            chk("st_cnt", 32'(count_b), 32'(st_cnt[i]));
            chk("st_done", 32'(done_b), 32'(st_dn[i]));
        end
        shift_en_b = 1'b0;
        step();

        // abort in RUN, then load+shift precedence
        base = pulses_b;
        load_b_op(16'h00F0, 1'b0, 1'b0, 1'b0);
        shift_en_b = 1'b1;
        step(); step();
        chk("ab_pre_q", 32'(q_b), 32'h03C0);
        chk("ab_pre_cnt", 32'(count_b), 32'd2);
        load_b_op(16'hABCD, 1'b0, 1'b0, 1'b0);
        chk("ab_q", 32'(q_b), 32'hABCD);
        chk("ab_cnt", 32'(count_b), 32'd0);
        chk("ab_busy", 32'(busy_b), 32'h1);
        chk("ab_done", 32'(done_b), 32'h0);
        load_b_op(16'h1234, 1'b0, 1'b0, 1'b1);
        chk("pr_q", 32'(q_b), 32'h1234);
        chk("pr_cnt", 32'(count_b), 32'd0);
        step(); step(); step(); step();
        chk("pr_fin_q", 32'(q_b), 32'h2340);
        chk("pr_fin_ob", 32'(out_bit_b), 32'h1);
        chk("pr_fin_done", 32'(done_b), 32'h1);
        shift_en_b = 1'b0;
        step(); step();
        chk("ab_pulses", 32'(pulses_b - base), 32'd1);

        // back-to-back: reload in the DONE cycle
        base = pulses_b;
        load_b_op(16'h000F, 1'b1, 1'b1, 1'b0);
        shift_en_b = 1'b1;
        step(); step(); step(); step();
        chk("bb1_q", 32'(q_b), 32'hF000);
        chk("bb1_done", 32'(done_b), 32'h1);
        load_b_op(16'h1111, 1'b0, 1'b0, 1'b1);
        chk("bb2_busy", 32'(busy_b), 32'h1);
        chk("bb2_q", 32'(q_b), 32'h1111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bb2_q_s", 32'(q_b), 32'(bb_q[i]));
            chk("bb2_busy_s", 32'(busy_b), (i == 3) ? 32'h0 : 32'h1);
        end
        chk("bb2_done", 32'(done_b), 32'h1);
        shift_en_b = 1'b0;
        step(); step();
        chk("bb_pulses", 32'(pulses_b - base), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule

// File: doc/div_shift_reg.md
# div_shift_reg

Parametrised, sequential quotient/remainder shift register for the iterative divider in the ALU. It holds a WIDTH-bit word, shifts it one position per enabled cycle in a selectable direction, and inserts a caller-supplied bit at the vacated end. The combinational version only shifted left with a hard-wired 1. This block also counts steps, exposes the shifted-out bit, and signals completion after STEPS shifts, so the divider control only supplies the per-cycle quotient bit.

## Interface
- WIDTH, 32, register width in bits (≥2)
- STEPS, 16, shifts per operation (1..WIDTH); also the counter terminal value
- CW, $clog2(STEPS+1), step-counter width (derived, not overridden)

- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  start strobe; captures load_val and begins an operation
- load_val  in  WIDTH  initial register contents
- dir  in  1  0 = shift left (insert at bit 0), 1 = shift right (insert at bit WIDTH-1); sampled on load, held for the operation
- shift_en  in  1  perform one shift this cycle (honoured only in RUN)
- ins_bit  in  1  bit inserted at the vacated position on a shift
- q  out  WIDTH  register contents
- out_bit  out  1  bit shifted out by the most recent shift (q[WIDTH-1] before a left shift, q[0] before a right shift)
- count  out  CW  shifts completed in the current operation
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE

## Operation
- States:
  - IDLE: waits for load.
  - RUN: shifting until count reaches STEPS.
  - DONE: one cycle, then back to IDLE.
- IDLE + load: q←load_val, dir latched, count←0, out_bit←0, go to RUN.
- RUN + shift_en, left: q←{q[WIDTH-2:0], ins_bit}; out_bit←old q[WIDTH-1]; count←count+1.
- RUN + shift_en, right: q←{ins_bit, q[WIDTH-1:1]}; out_bit←old q[0]; count←count+1.
- RUN with shift_en low: all state holds; stalls of any length are legal.
- When the shift that makes count = STEPS occurs, go to DONE on that same edge.
- DONE: done=1 for one cycle; q, count and out_bit hold; go to IDLE next.
- load in RUN or DONE: restarts the operation (abort). q←load_val, count←0, go to RUN, no done pulse.
- load and shift_en in the same cycle: load wins and the shift is discarded.
- In IDLE, shift_en is ignored and q holds the last result until the next load.
- count never exceeds STEPS and never wraps.
- Legacy equivalence: STEPS=WIDTH-1, dir=0, ins_bit=1 per step. Each step matches the old combinational shift, k={a[WIDTH-2:0],1}.

## Timing
- Reset (async assert, synchronous release on the next clk edge): state=IDLE, q=0, count=0, out_bit=0, busy=0, done=0.
- Reset mid-operation aborts immediately with no done pulse.
- All outputs are registered; no combinational input→output paths.
- load at edge N: q=load_val and busy=1 after edge N.
- Latency: with shift_en held high from the cycle after load, done is high in cycle load+STEPS+1 and busy falls in the same cycle.
- A new load is accepted in the DONE cycle, giving back-to-back operations with no idle gap.

## Structure
- Shared package div_pkg:
  - state enum: IDLE, RUN, DONE.
  - direction constants: DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - default WIDTH/STEPS constants shared with the divider control.
- One natural sub-module: div_step_counter (CW-bit saturating up-counter with clear, enable and terminal-count flag). The datapath shift and FSM stay in the top module.

## Test plan
- Reset and idle:
  - Assert rst_n=0 mid-RUN at count=5 → all outputs 0 immediately, no done pulse.
  - After release, shift_en in IDLE leaves q=0.
- Legacy left-shift, WIDTH=32, STEPS=31: load 32'h0000_0001, dir=0, ins_bit=1, shift_en high → after 1 shift q=32'h0000_0003.
  - After 31 shifts q=32'hFFFF_FFFF, out_bit=0, done pulses in cycle 32 after load, count=31.
- Right shift, WIDTH=16, STEPS=4: load 16'h8001, dir=1, ins_bit=0 → q=16'h4000 after shift 1 with out_bit=1.
  - After shift 4, q=16'h0800 and done pulses once.
- Stalls: STEPS=4 with shift_en pattern 1,0,0,1,0,1,1 → done only after the 4th enabled shift; q and count hold on the low cycles.
- Abort and precedence:
  - load in RUN at count=2 → count=0, q=new load_val, no done pulse.
  - load and shift_en together → q=load_val, unshifted.
- Back-to-back: assert load during the DONE cycle → busy stays high, the second operation completes in STEPS further enabled cycles, and exactly two done pulses occur.
